arb_mem: RTL
============

ARB_MEM -- requirements
Module: arb_mem

Interface
REQ-001 The block SHALL have parameter AW, default 12, meaning address width in bits; depth is 2**AW words.
REQ-002 The block SHALL have parameter DW, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter NCH, default 2, range 1..8, meaning the number of requester channels.
REQ-004 The block SHALL have parameter PROT_LIMIT, default 'h200, meaning the first writable address when write protection is compiled in.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  NCH  per-channel access request; bit i belongs to channel i.
REQ-008 we  input  NCH  per-channel write enable; 1 = write, 0 = read; sampled with req.
REQ-009 addr  input  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
REQ-010 wdata  input  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW].
REQ-011 ack  output  NCH  per-channel one-cycle completion pulse.
REQ-012 rdata  output  DW  read data, shared by all channels; valid while any ack bit is high.
REQ-013 wr_err  output  1  one-cycle pulse: a write was rejected by protection.

Function
REQ-014 The storage SHALL be a single-port array of 2**AW words of DW bits, performing at most one access per cycle.
REQ-015 Eligible channels SHALL be those with req[i]=1 and ack[i]=0 in the current cycle.
REQ-016 The arbiter SHALL grant exactly one eligible channel per cycle, chosen round-robin starting from the channel after the last granted one.
REQ-017 After reset the round-robin search SHALL start at channel 0; the pointer SHALL advance only on a grant.
REQ-018 A granted read SHALL update rdata with data[addr] and assert ack for that channel on the next rising edge: latency exactly 1 cycle.
REQ-019 A granted write SHALL store wdata at addr on the next rising edge and assert ack for that channel on that same edge; rdata SHALL keep its previous value.
REQ-020 ack SHALL be high for exactly one cycle per grant, with at most one ack bit high in any cycle.
REQ-021 A requester SHALL hold req, we, addr and wdata stable until its ack, and MAY keep req high afterwards to issue a new access; the ack-cycle exclusion of REQ-015 SHALL prevent double service.
REQ-022 A single channel requesting continuously SHALL be served every second cycle; with two or more channels requesting, the array SHALL be accessed every cycle.
REQ-023 A read of an address written in the previous cycle SHALL return the new data.
REQ-024 Requests with req=0 SHALL be ignored regardless of we, addr or wdata.
REQ-025 The address SHALL be used modulo 2**AW with no range checks, apart from protection.

Reset
REQ-026 While reset is high, ack, wr_err and rdata SHALL be 0, the round-robin pointer SHALL be at channel 0, and no access SHALL be granted.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A write granted in the cycle in which reset asserts SHALL NOT be required to complete; its ack SHALL be suppressed.

Configuration
REQ-029 With macro MEM_WRITE_PROTECT_EN defined, a granted write with addr < PROT_LIMIT SHALL leave memory unchanged, still ack on the next edge, and pulse wr_err in that same cycle.
REQ-030 Without MEM_WRITE_PROTECT_EN, all addresses SHALL be writable, and wr_err SHALL be tied to 0.

Verification
REQ-031 Channel 0 writes 'hAB to 'h300, then reads 'h300 -> ack0 one cycle after each grant, and rdata='hAB in the read ack cycle.
REQ-032 Channels 0 and 1 both hold req continuously from reset -> grants alternate 0,1,0,1, one ack per cycle, and no channel is acked on two consecutive cycles.
REQ-033 Channel 1 writes 'h5A to 'h010 with MEM_WRITE_PROTECT_EN defined -> ack1 and wr_err pulse together and a read of 'h010 returns the old value; without the macro, wr_err=0 and the read returns 'h5A.
REQ-034 Channel 0 writes 'h11 to 'hFFF, and next cycle channel 1 reads 'hFFF -> rdata='h11 (REQ-023).
REQ-035 Reset is asserted asynchronously mid-stream while both channels request -> ack, rdata and wr_err go to 0 immediately; after release the first grant goes to channel 0, and previously written data is intact.
REQ-036 NCH=4, AW=8, DW=16, with all four channels reading distinct addresses -> four acks over four consecutive cycles in order 0,1,2,3, each with the correct 16-bit data.

Source files
------------

// File: rtl/arb_mem.sv
// Single-port memory shared by NCH requesters through a round-robin arbiter.
// Define MEM_WRITE_PROTECT_EN to reject writes below PROT_LIMIT and pulse wr_err.
module arb_mem #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 8,
  parameter int unsigned NCH        = 2,
  parameter int unsigned PROT_LIMIT = 'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              wr_err
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DW-1:0]  mem [2**AW];

  logic [NCH-1:0] ack_q, ack_d, elig;
  logic [DW-1:0]  rdata_q;
  logic           wr_err_q, wr_err_d;
  logic [PW-1:0]  ptr_q, ptr_d, gnt_idx, cand;
  logic           gnt_vld, g_we, prot_hit, mem_wr, rd_en;
  logic [AW-1:0]  g_addr;
  logic [DW-1:0]  g_wdata;

  // A channel acked this cycle is excluded, so a held req is not served twice.
  always_comb begin
    elig    = req & ~ack_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      cand = PW'((int'(ptr_q) + k) % int'(NCH));
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (reset) begin
      gnt_vld = 1'b0;
    end
  end

  assign g_we    = we[gnt_idx];
  assign g_addr  = addr[gnt_idx*AW +: AW];
  assign g_wdata = wdata[gnt_idx*DW +: DW];

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_hit = (32'(g_addr) < PROT_LIMIT);
`else
  logic unused_prot;
  assign prot_hit    = 1'b0;
  assign unused_prot = ^PROT_LIMIT;
`endif

  always_comb begin
    mem_wr   = gnt_vld & g_we & ~prot_hit;
    rd_en    = gnt_vld & ~g_we;
    wr_err_d = gnt_vld & g_we & prot_hit;
    ack_d    = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    ptr_d    = gnt_vld ? PW'((int'(gnt_idx) + 1) % int'(NCH)) : ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q    <= '0;
      rdata_q  <= '0;
      wr_err_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      wr_err_q <= wr_err_d;
      ptr_q    <= ptr_d;
      if (rd_en) begin
        rdata_q <= mem[g_addr];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[g_addr] <= g_wdata;
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign wr_err = wr_err_q;

endmodule
